mtime_counter: RTL and testbench

// - Free-running 48-bit machine-time source; drives the mtime bus consumed by the mtimecmp/interrupt comparator.
// - Programmable prescaler, enable, software load of mtime, sticky wrap flag, memory-mapped on the peripheral bus.
// - One instance per SoC, clocked from the core clock; mtime output is registered.

---
 rtl/mtime_counter.sv | 145 ++++++++++++++
 tb/tb_mtime_counter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtime_counter.sv
// mtime_counter: free-running 48-bit machine-time counter with prescaler, enable, software load and sticky wrap flag.
// Optional macro MTIME_SNAPSHOT_EN: MTIME_LO reads latch mtime[47:32] so a following MTIME_HI read is coherent.
module mtime_counter #(
   parameter logic [31:0] MTIME_BASE_ADDR = 32'h4000_2100,
   parameter int unsigned PRESC_W         = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic        mem_we,
   input  logic        mem_re,
   output logic [31:0] mem_rdata,
   output logic [47:0] mtime,
   output logic        mtime_tick
);

   localparam logic [3:0]         OFF_LO     = 4'h0;
   localparam logic [3:0]         OFF_HI     = 4'h4;
   localparam logic [3:0]         OFF_CTRL   = 4'h8;
   localparam logic [3:0]         OFF_STATUS = 4'hC;
   localparam logic [PRESC_W-1:0] PCNT_ONE   = PRESC_W'(1);

   logic [47:0]        mtime_q, mtime_d;
   logic [PRESC_W-1:0] pcnt_q, pcnt_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic               en_q, en_d;
   logic               ovf_q, ovf_d;
   logic               tick_q, tick_d;

   logic               sel;
   logic [3:0]         offset;
   logic               wr_lo, wr_hi, wr_ctrl, wr_status;
   logic               tick_due;
   logic [15:0]        hi_rd;
   logic [31:0]        ctrl_rd;
   logic               unused_addr;

   assign sel         = (mem_addr[31:8] == MTIME_BASE_ADDR[31:8]);
   assign offset      = mem_addr[3:0];
   assign unused_addr = ^mem_addr[7:4];

   assign wr_lo     = sel && mem_we && (offset == OFF_LO);
   assign wr_hi     = sel && mem_we && (offset == OFF_HI);
   assign wr_ctrl   = sel && mem_we && (offset == OFF_CTRL);
   assign wr_status = sel && mem_we && (offset == OFF_STATUS);

   assign tick_due = en_q && (pcnt_q == presc_q);

   // A software load of mtime suppresses the increment due that cycle; a CTRL write does not.
   always_comb begin
      mtime_d = mtime_q;
      pcnt_d  = pcnt_q;
      presc_d = presc_q;
      en_d    = en_q;
      ovf_d   = ovf_q;
      tick_d  = 1'b0;

      if (wr_status && mem_wdata[0]) begin
         ovf_d = 1'b0;
      end

      if (wr_lo || wr_hi) begin
         pcnt_d = '0;
         if (wr_lo) begin
            mtime_d[31:0] = mem_wdata;
         end else begin
            mtime_d[47:32] = mem_wdata[15:0];
         end
      end else begin
         if (tick_due) begin
            mtime_d = mtime_q + 48'd1;
            pcnt_d  = '0;
            tick_d  = 1'b1;
            if (&mtime_q) begin
               ovf_d = 1'b1;
            end
         end else if (en_q) begin
            pcnt_d = pcnt_q + PCNT_ONE;
         end
         if (wr_ctrl) begin
            en_d    = mem_wdata[0];
            presc_d = mem_wdata[8 +: PRESC_W];
            pcnt_d  = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mtime_q <= '0;
         pcnt_q  <= '0;
         presc_q <= '0;
         en_q    <= 1'b1;
         ovf_q   <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         mtime_q <= mtime_d;
         pcnt_q  <= pcnt_d;
         presc_q <= presc_d;
         en_q    <= en_d;
         ovf_q   <= ovf_d;
         tick_q  <= tick_d;
      end
   end

`ifdef MTIME_SNAPSHOT_EN
   logic [15:0] shadow_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= '0;
      end else if (sel && mem_re && (offset == OFF_LO)) begin
         shadow_q <= mtime_q[47:32];
      end
   end

   assign hi_rd = shadow_q;
`else
   assign hi_rd = mtime_q[47:32];
`endif

   always_comb begin
      ctrl_rd                = '0;
      ctrl_rd[0]             = en_q;
      ctrl_rd[8 +: PRESC_W]  = presc_q;
   end

   always_comb begin
      mem_rdata = '0;
      if (sel && mem_re) begin
         case (offset)
            OFF_LO:     mem_rdata = mtime_q[31:0];
            OFF_HI:     mem_rdata = {16'h0, hi_rd};
            OFF_CTRL:   mem_rdata = ctrl_rd;
            OFF_STATUS: mem_rdata = {31'h0, ovf_q};
            default:    mem_rdata = '0;
         endcase
      end
   end

   assign mtime      = mtime_q;
   assign mtime_tick = tick_q;

endmodule

// File: tb/tb_mtime_counter.sv
// Self-checking bench for mtime_counter: fixed vector table, hand-written corner sequences,
// then random bus traffic compared against a cycle-level behavioural model.
module tb_mtime_counter;

   localparam logic [31:0] BASE    = 32'h4000_2100;
   localparam logic [31:0] A_LO    = BASE;
   localparam logic [31:0] A_HI    = BASE + 32'h4;
   localparam logic [31:0] A_CTRL  = BASE + 32'h8;
   localparam logic [31:0] A_ST    = BASE + 32'hC;
   localparam logic [31:0] A_OTHER = BASE + 32'h3;
   localparam logic [31:0] A_FAR   = 32'h4000_2200;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_we, mem_re;
   logic [47:0] mtime;
   logic        mtime_tick;

   int vectors     = 0;
   int miscompares = 0;

   mtime_counter #(
      .MTIME_BASE_ADDR (BASE),
      .PRESC_W         (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_re     (mem_re),
      .mem_rdata  (mem_rdata),
      .mtime      (mtime),
      .mtime_tick (mtime_tick)
   );

   always #5 clk = ~clk;

   // Reference model: time value, cycles elapsed in the current prescale period, control and flags.
   logic [47:0] m_time;
   int unsigned m_phase;
   bit          m_en;
   int unsigned m_presc;
   bit          m_ovf;
   bit          m_tick;
   logic [15:0] m_shadow;

   typedef struct {
      logic        we;
      logic        re;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rd;
      logic [47:0] mt;
      logic        tk;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_time   = '0;
      m_phase  = 0;
      m_en     = 1'b1;
      m_presc  = 0;
      m_ovf    = 1'b0;
      m_tick   = 1'b0;
      m_shadow = '0;
   endtask

   function automatic logic [31:0] model_read(input logic re, input logic [31:0] addr);
      logic [31:0] r;
      logic [15:0] hi;
      r = '0;
`ifdef MTIME_SNAPSHOT_EN
      hi = m_shadow;
`else
      hi = m_time[47:32];
`endif
      if (re && (addr[31:8] == BASE[31:8])) begin
         case (addr[3:0])
            4'h0:    r = m_time[31:0];
            4'h4:    r = {16'h0, hi};
            4'h8:    r = {8'h0, 16'(m_presc), 7'h0, m_en};
            4'hC:    r = {31'h0, m_ovf};
            default: r = '0;
         endcase
      end
      return r;
   endfunction

   task automatic model_clock(input logic we, input logic re, input logic [31:0] addr, input logic [31:0] wdata);
      bit         sel;
      bit         due;
      bit         wrapped;
      logic [3:0] off;
      sel     = (addr[31:8] == BASE[31:8]);
      off     = addr[3:0];
      due     = m_en && (m_phase == m_presc);
      wrapped = 1'b0;
`ifdef MTIME_SNAPSHOT_EN
      if (sel && re && off == 4'h0) m_shadow = m_time[47:32];
`else
      if (sel && re && off == 4'h0) m_shadow = m_shadow;
`endif
      if (sel && we && off == 4'h0) begin
         m_time[31:0] = wdata;
         m_phase      = 0;
         m_tick       = 1'b0;
      end else if (sel && we && off == 4'h4) begin
         m_time[47:32] = wdata[15:0];
         m_phase       = 0;
         m_tick        = 1'b0;
      end else begin
         m_tick = due;
         if (due) begin
            wrapped = (m_time == 48'hFFFF_FFFF_FFFF);
            m_time  = m_time + 48'd1;
            m_phase = 0;
         end else if (m_en) begin
            m_phase = m_phase + 1;
         end
         if (sel && we && off == 4'h8) begin
            m_en    = wdata[0];
            m_presc = int'(wdata[23:8]);
            m_phase = 0;
         end
      end
      if (sel && we && off == 4'hC && wdata[0]) m_ovf = 1'b0;
      if (wrapped) m_ovf = 1'b1;
   endtask

   task automatic run_step(input logic we, input logic re, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rd, output logic [47:0] mt, output logic tk);
      mem_we    = we;
      mem_re    = re;
      mem_addr  = addr;
      mem_wdata = wdata;
      #4;
      rd = mem_rdata;
      @(posedge clk);
      model_clock(we, re, addr, wdata);
      #1;
      mt = mtime;
      tk = mtime_tick;
   endtask

   task automatic hstep(input logic we, input logic re, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] e_rd, input logic [47:0] e_mt, input logic e_tk, input string name);
      logic [31:0] rd;
      logic [47:0] mt;
      logic        tk;
      run_step(we, re, addr, wdata, rd, mt, tk);
      check({name, "_rdata"}, rd, e_rd);
      check({name, "_mtime"}, mt, e_mt);
      check({name, "_tick"}, tk, e_tk);
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_mtime", mtime, 48'h0);
      check("reset_tick", mtime_tick, 1'b0);
      mem_re   = 1'b1;
      mem_addr = A_CTRL;
      #1;
      check("reset_ctrl", mem_rdata, 32'h1);
      mem_addr = A_ST;
      #1;
      check("reset_status", mem_rdata, 32'h0);
      mem_re = 1'b0;
      rst_n  = 1'b1;
   endtask

   task automatic add(input logic we, input logic re, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] rd, input logic [47:0] mt, input logic tk);
      vec_t v;
      v.we = we; v.re = re; v.addr = addr; v.wdata = wdata;
      v.rd = rd; v.mt = mt; v.tk = tk;
      tbl.push_back(v);
   endtask

   initial begin
      logic [31:0] rd, exp_rd, a_r, wd_r;
      logic [47:0] mt;
      logic        tk, we_r, re_r;
      logic [3:0]  off;
      int unsigned pick;

      // we  re  addr                  wdata              rdata         mtime after edge        tick
      add(0, 1, A_LO,                  32'h0,             32'h0,        48'd1,                  1);
      add(0, 1, A_LO,                  32'h0,             32'h1,        48'd2,                  1);
      add(0, 1, A_CTRL,                32'h0,             32'h1,        48'd3,                  1);
      add(1, 1, A_CTRL,                32'h0000_0301,     32'h1,        48'd4,                  1);
      add(0, 0, A_LO,                  32'h0,             32'h0,        48'd4,                  0);
      add(0, 1, A_LO,                  32'h0,             32'h4,        48'd4,                  0);
      add(0, 0, A_LO,                  32'h0,             32'h0,        48'd4,                  0);
      add(0, 1, A_CTRL,                32'h0,             32'h301,      48'd5,                  1);
      add(0, 0, A_LO,                  32'h0,             32'h0,        48'd5,                  0);
      add(1, 0, A_CTRL,                32'h0,             32'h0,        48'd5,                  0);
      add(0, 1, A_CTRL,                32'h0,             32'h0,        48'd5,                  0);
      add(1, 0, A_HI,                  32'h1234_FFFF,     32'h0,        48'hFFFF_0000_0005,     0);
      add(1, 0, A_LO,                  32'hFFFF_FFFE,     32'h0,        48'hFFFF_FFFF_FFFE,     0);
      add(1, 0, A_CTRL,                32'h1,             32'h0,        48'hFFFF_FFFF_FFFE,     0);
      add(0, 1, A_ST,                  32'h0,             32'h0,        48'hFFFF_FFFF_FFFF,     1);
      add(0, 1, A_ST,                  32'h0,             32'h0,        48'h0,                  1);
      add(0, 1, A_ST,                  32'h0,             32'h1,        48'd1,                  1);
      add(1, 1, A_ST,                  32'h1,             32'h1,        48'd2,                  1);
      add(0, 1, A_ST,                  32'h0,             32'h0,        48'd3,                  1);
      add(0, 1, A_FAR,                 32'h0,             32'h0,        48'd4,                  1);
      add(1, 0, A_FAR,                 32'h0000_1000,     32'h0,        48'd5,                  1);
      add(1, 1, A_OTHER,               32'hFFFF_FFFF,     32'h0,        48'd6,                  1);
      add(0, 1, A_HI,                  32'h0,             32'h0,        48'd7,                  1);
      add(1, 1, A_CTRL,                32'hAB00_0201,     32'h1,        48'd8,                  1);
      add(0, 1, A_CTRL,                32'h0,             32'h201,      48'd8,                  0);
      add(0, 0, A_LO,                  32'h0,             32'h0,        48'd8,                  0);
      add(0, 0, A_LO,                  32'h0,             32'h0,        48'd9,                  1);

      do_reset();
      for (int i = 0; i < tbl.size(); i++) begin
         hstep(tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].wdata,
               tbl[i].rd, tbl[i].mt, tbl[i].tk, $sformatf("tbl%0d", i));
      end

      // Disable holds mtime for 50 clocks, re-enable resumes.
      do_reset();
      hstep(1, 0, A_LO, 32'd100, 32'h0, 48'd100, 1'b0, "en_load");
      hstep(1, 0, A_CTRL, 32'h0, 32'h0, 48'd101, 1'b1, "en_off");
      for (int i = 0; i < 50; i++) begin
         hstep(0, 0, A_LO, 32'h0, 32'h0, 48'd101, 1'b0, $sformatf("en_hold%0d", i));
      end
      hstep(1, 0, A_CTRL, 32'h1, 32'h0, 48'd101, 1'b0, "en_on");
      hstep(0, 0, A_LO, 32'h0, 32'h0, 48'd102, 1'b1, "en_resume0");
      hstep(0, 0, A_LO, 32'h0, 32'h0, 48'd103, 1'b1, "en_resume1");

      // LO read then HI read across a carry into the upper half.
      do_reset();
      hstep(1, 0, A_CTRL, 32'h0, 32'h0, 48'd1, 1'b1, "snap_stop");
      hstep(1, 0, A_HI, 32'h0, 32'h0, 48'd1, 1'b0, "snap_hi");
      hstep(1, 0, A_LO, 32'hFFFF_FFFF, 32'h0, 48'h0000_FFFF_FFFF, 1'b0, "snap_lo");
      hstep(0, 1, A_LO, 32'h0, 32'hFFFF_FFFF, 48'h0000_FFFF_FFFF, 1'b0, "snap_rdlo");
      hstep(1, 0, A_CTRL, 32'h1, 32'h0, 48'h0000_FFFF_FFFF, 1'b0, "snap_go");
      hstep(0, 0, A_LO, 32'h0, 32'h0, 48'h0001_0000_0000, 1'b1, "snap_carry");
`ifdef MTIME_SNAPSHOT_EN
      hstep(0, 1, A_HI, 32'h0, 32'h0, 48'h0001_0000_0001, 1'b1, "snap_rdhi");
`else
      hstep(0, 1, A_HI, 32'h0, 32'h1, 48'h0001_0000_0001, 1'b1, "snap_rdhi");
`endif

      // Wrap with concurrent W1C, then asynchronous reset mid-cycle.
      do_reset();
      hstep(1, 0, A_CTRL, 32'h0000_0501, 32'h0, 48'd1, 1'b1, "ar_ctrl");
      hstep(1, 0, A_HI, 32'h0000_FFFF, 32'h0, 48'hFFFF_0000_0001, 1'b0, "ar_hi");
      hstep(1, 0, A_LO, 32'hFFFF_FFFF, 32'h0, 48'hFFFF_FFFF_FFFF, 1'b0, "ar_lo");
      for (int i = 0; i < 5; i++) begin
         hstep(0, 0, A_LO, 32'h0, 32'h0, 48'hFFFF_FFFF_FFFF, 1'b0, $sformatf("ar_wait%0d", i));
      end
      hstep(1, 0, A_ST, 32'h1, 32'h0, 48'h0, 1'b1, "ar_wrap_w1c");
      hstep(0, 1, A_ST, 32'h0, 32'h1, 48'h0, 1'b0, "ar_ovf_set_wins");
      hstep(1, 0, A_LO, 32'h1234, 32'h0, 48'h1234, 1'b0, "ar_load");
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("ar_async_mtime", mtime, 48'h0);
      check("ar_async_tick", mtime_tick, 1'b0);
      mem_re   = 1'b1;
      mem_addr = A_ST;
      #1;
      check("ar_async_status", mem_rdata, 32'h0);
      mem_addr = A_CTRL;
      #1;
      check("ar_async_ctrl", mem_rdata, 32'h1);
      mem_re = 1'b0;
      @(posedge clk);
      #1;
      check("ar_held_mtime", mtime, 48'h0);
      rst_n = 1'b1;
      hstep(0, 0, A_LO, 32'h0, 32'h0, 48'd1, 1'b1, "ar_restart");

      // Random bus traffic against the model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         we_r = ($urandom_range(0, 99) < 15);
         re_r = 1'($urandom_range(0, 1));
         pick = $urandom_range(0, 7);
         case (pick)
            0, 1:    off = 4'h0;
            2:       off = 4'h4;
            3, 4:    off = 4'h8;
            5:       off = 4'hC;
            default: begin
               off = 4'($urandom);
               if (off[1:0] == 2'b00) off[0] = 1'b1;
            end
         endcase
         a_r = {BASE[31:8], 4'($urandom), off};
         if (pick == 7) a_r[31:8] = 24'h40_0022 + 24'($urandom_range(0, 3));
         wd_r = $urandom;
         if (off == 4'h8) begin
            wd_r[23:8] = 16'($urandom_range(0, 4));
            wd_r[0]    = ($urandom_range(0, 4) != 0);
         end else if (off == 4'h4 && $urandom_range(0, 1) == 1) begin
            wd_r[15:0] = 16'hFFFF;
         end else if (off == 4'h0 && $urandom_range(0, 1) == 1) begin
            wd_r = 32'hFFFF_FFFF - 32'($urandom_range(0, 6));
         end
         exp_rd = model_read(re_r, a_r);
         run_step(we_r, re_r, a_r, wd_r, rd, mt, tk);
         check($sformatf("rnd%0d_rdata", i), rd, exp_rd);
         check($sformatf("rnd%0d_mtime", i), mt, m_time);
         check($sformatf("rnd%0d_tick", i), tk, m_tick);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
